// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake bundle: the retiring instruction from the MEM stage plus the
// data-memory read response that completes loads.
interface wb_stage_if #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [RF_ADDR_W-1:0] rd;
    logic [XLEN-1:0]      res;
    logic [XLEN-1:0]      pc;
    logic [2:0]           addr_lsb;
    logic [XLEN-1:0]      d_data_read;
    logic                 d_ack;

    modport master (
        output in_valid, opcode, funct3, rd, res, pc, addr_lsb, d_data_read, d_ack,
        input  in_ready
    );

    modport slave (
        input  in_valid, opcode, funct3, rd, res, pc, addr_lsb, d_data_read, d_ack,
        output in_ready
    );
endinterface

// File: rtl/wb_stage.sv
// Registered write-back stage: selects the result, extends sub-word loads, stalls
// for late load data, and counts retired instructions.
module wb_stage #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5,
    parameter int CNT_W     = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    wb_stage_if.slave            mem,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [CNT_W-1:0]     retired
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [RF_ADDR_W-1:0] rd_r;
    logic [2:0]           funct3_r;
    logic [2:0]           addr_lsb_r;

    logic                 is_load_s;
    logic                 complete_s;
    logic                 we_s;
    logic [RF_ADDR_W-1:0] waddr_s;
    logic [XLEN-1:0]      wdata_s;
    logic                 in_ready_s;

    // For XLEN=32 the top address bit never selects a lane, so LW/LWU see the whole word.
    function automatic logic [XLEN-1:0] extend_load(
        input logic [XLEN-1:0] data,
        input logic [2:0]      f3,
        input logic [2:0]      lsb
    );
        logic [5:0]      b_sh;
        logic [5:0]      h_sh;
        logic [5:0]      w_sh;
        logic [XLEN-1:0] b_lane;
        logic [XLEN-1:0] h_lane;
        logic [XLEN-1:0] w_lane;
        logic [XLEN-1:0] r;
        b_sh   = (XLEN == 64) ? {lsb, 3'b000}      : {1'b0, lsb[1:0], 3'b000};
        h_sh   = (XLEN == 64) ? {lsb[2:1], 4'b0000} : {1'b0, lsb[1], 4'b0000};
        w_sh   = (XLEN == 64) ? {lsb[2], 5'b00000}  : 6'b000000;
        b_lane = data >> b_sh;
        h_lane = data >> h_sh;
        w_lane = data >> w_sh;
        case (f3)
            3'b000: begin r = {XLEN{b_lane[7]}};  r[7:0]  = b_lane[7:0];  end
            3'b001: begin r = {XLEN{h_lane[15]}}; r[15:0] = h_lane[15:0]; end
            3'b010: begin r = {XLEN{w_lane[31]}}; r[31:0] = w_lane[31:0]; end
            3'b100: begin r = {XLEN{1'b0}};       r[7:0]  = b_lane[7:0];  end
            3'b101: begin r = {XLEN{1'b0}};       r[15:0] = h_lane[15:0]; end
            3'b110: begin r = {XLEN{1'b0}};       r[31:0] = w_lane[31:0]; end
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic writes_rf(input logic [6:0] op);
        return (op != OP_STORE) && (op != OP_BRANCH);
    endfunction

    assign is_load_s    = (mem.opcode == OP_LOAD);
    assign mem.in_ready = in_ready_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (mem.in_valid && is_load_s && !mem.d_ack) begin
                    next_state_s = WAIT_LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (mem.d_ack) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_LOAD;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode: handshake ready, completion and the write to be registered.
    always_comb begin
        in_ready_s = 1'b0;
        complete_s = 1'b0;
        we_s       = 1'b0;
        waddr_s    = mem.rd;
        wdata_s    = mem.res;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                complete_s = mem.in_valid && (!is_load_s || mem.d_ack);
                we_s       = complete_s && writes_rf(mem.opcode) && (mem.rd != '0);
                waddr_s    = mem.rd;
                if (is_load_s) begin
                    wdata_s = extend_load(mem.d_data_read, mem.funct3, mem.addr_lsb);
                end else if ((mem.opcode == OP_JAL) || (mem.opcode == OP_JALR)) begin
                    wdata_s = mem.pc + {{(XLEN-3){1'b0}}, 3'b100};
                end else begin
                    wdata_s = mem.res;
                end
            end
            WAIT_LOAD: begin
                in_ready_s = 1'b0;
                complete_s = mem.d_ack;
                we_s       = mem.d_ack && (rd_r != '0);
                waddr_s    = rd_r;
                wdata_s    = extend_load(mem.d_data_read, funct3_r, addr_lsb_r);
            end
            default: begin
                in_ready_s = 1'b0;
                complete_s = 1'b0;
            end
        endcase
    end

    // Hold the load fields while waiting for the memory response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_r       <= '0;
            funct3_r   <= 3'b000;
            addr_lsb_r <= 3'b000;
        end else if ((state_r == IDLE) && mem.in_valid && is_load_s && !mem.d_ack) begin
            rd_r       <= mem.rd;
            funct3_r   <= mem.funct3;
            addr_lsb_r <= mem.addr_lsb;
        end else begin
            rd_r       <= rd_r;
            funct3_r   <= funct3_r;
            addr_lsb_r <= addr_lsb_r;
        end
    end

    // Registered write port and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            retired  <= '0;
        end else begin
            rf_we   <= we_s;
            retired <= retired + {{(CNT_W-1){1'b0}}, complete_s};
            if (we_s) begin
                rf_waddr <= waddr_s;
                rf_wdata <= wdata_s;
            end else begin
                rf_waddr <= rf_waddr;
                rf_wdata <= rf_wdata;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a 32-bit instance for the main checks and a 64-bit
// instance for word-lane selection and LWU zero extension.
module tb_wb_stage;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(32), .RF_ADDR_W(5)) b32 ();
    wb_stage_if #(.XLEN(64), .RF_ADDR_W(5)) b64 ();

    logic        we32, we64;
    logic [4:0]  wa32, wa64;
    logic [31:0] wd32;
    logic [63:0] wd64;
    logic [63:0] ret32, ret64;

    wb_stage #(.XLEN(32), .RF_ADDR_W(5), .CNT_W(64)) u32 (
        .clk(clk), .reset(reset), .mem(b32),
        .rf_we(we32), .rf_waddr(wa32), .rf_wdata(wd32), .retired(ret32)
    );

    wb_stage #(.XLEN(64), .RF_ADDR_W(5), .CNT_W(64)) u64 (
        .clk(clk), .reset(reset), .mem(b64),
        .rf_we(we64), .rf_waddr(wa64), .rf_wdata(wd64), .retired(ret64)
    );

    localparam logic [6:0] ADD = 7'b0110011, LOAD = 7'b0000011, JAL = 7'b1101111;
    localparam logic [6:0] AUIPC = 7'b0010111, STORE = 7'b0100011;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv32(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc,
                         input logic [2:0] lsb, input logic [31:0] data, input logic ack);
        b32.in_valid = v;   b32.opcode = op;    b32.funct3 = f3; b32.rd = rd;
        b32.res = res;      b32.pc = pc;        b32.addr_lsb = lsb;
        b32.d_data_read = data; b32.d_ack = ack;
    endtask

    task automatic drv64(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [2:0] lsb,
                         input logic [63:0] data, input logic ack);
        b64.in_valid = v;   b64.opcode = op;    b64.funct3 = f3; b64.rd = rd;
        b64.res = 64'h0;    b64.pc = 64'h0;     b64.addr_lsb = lsb;
        b64.d_data_read = data; b64.d_ack = ack;
    endtask

    initial begin
        reset = 1'b1;
        drv32(1'b0, ADD, 3'b000, 5'd0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0);
        drv64(1'b0, ADD, 3'b000, 5'd0, 3'b000, 64'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("reset_we", {63'h0, we32}, 64'h0);
        chk("reset_waddr", {59'h0, wa32}, 64'h0);
        chk("reset_wdata", {32'h0, wd32}, 64'h0);
        chk("reset_retired", ret32, 64'h0);
        chk("reset_ready", {63'h0, b32.in_ready}, 64'h1);

        drv32(1'b1, ADD, 3'b000, 5'd5, 32'h1234, 32'h0, 3'b000, 32'h0, 1'b0);
        tick();
        chk("add_we", {63'h0, we32}, 64'h1);
        chk("add_waddr", {59'h0, wa32}, 64'd5);
        chk("add_wdata", {32'h0, wd32}, 64'h1234);
        chk("add_retired", ret32, 64'd1);

        drv32(1'b1, JAL, 3'b000, 5'd1, 32'h0, 32'h100, 3'b000, 32'h0, 1'b0);
        tick();
        chk("jal_wdata", {32'h0, wd32}, 64'h104);
        chk("jal_waddr", {59'h0, wa32}, 64'd1);

        drv32(1'b1, AUIPC, 3'b000, 5'd2, 32'h2000, 32'h300, 3'b000, 32'h0, 1'b0);
        tick();
        chk("auipc_wdata", {32'h0, wd32}, 64'h2000);

        drv32(1'b1, STORE, 3'b010, 5'd7, 32'h44, 32'h0, 3'b000, 32'h0, 1'b0);
        tick();
        chk("store_we", {63'h0, we32}, 64'h0);
        chk("store_retired", ret32, 64'd4);

        drv32(1'b1, LOAD, 3'b000, 5'd3, 32'h0, 32'h0, 3'b011, 32'h80FF7F01, 1'b1);
        tick();
        chk("lb_wdata", {32'h0, wd32}, 64'hFFFFFF80);
        chk("lb_we", {63'h0, we32}, 64'h1);

        drv32(1'b1, LOAD, 3'b100, 5'd3, 32'h0, 32'h0, 3'b011, 32'h80FF7F01, 1'b1);
        tick();
        chk("lbu_wdata", {32'h0, wd32}, 64'h00000080);

        drv32(1'b1, LOAD, 3'b001, 5'd4, 32'h0, 32'h0, 3'b010, 32'h80FF7F01, 1'b1);
        tick();
        chk("lh_wdata", {32'h0, wd32}, 64'hFFFF80FF);

        drv32(1'b1, ADD, 3'b000, 5'd0, 32'h99, 32'h0, 3'b000, 32'h0, 1'b0);
        tick();
        chk("rd0_we", {63'h0, we32}, 64'h0);
        chk("rd0_retired", ret32, 64'd8);

        // Idle cycle with a stray ack: nothing retires.
        drv32(1'b0, LOAD, 3'b000, 5'd6, 32'h0, 32'h0, 3'b000, 32'h12345678, 1'b1);
        tick();
        chk("stray_ack_we", {63'h0, we32}, 64'h0);
        chk("stray_ack_retired", ret32, 64'd8);

        // LW accepted without ack; ack arrives three cycles later while an ADD waits.
        drv32(1'b1, LOAD, 3'b010, 5'd9, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0);
        tick();
        drv32(1'b1, ADD, 3'b000, 5'd10, 32'h55, 32'h0, 3'b000, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wait_ready_%0d", i), {63'h0, b32.in_ready}, 64'h0);
            chk($sformatf("wait_we_%0d", i), {63'h0, we32}, 64'h0);
            if (i == 2) begin
                b32.d_ack = 1'b1;
                b32.d_data_read = 32'hDEADBEEF;
            end
            tick();
        end
        b32.d_ack = 1'b0;
        chk("lw_we", {63'h0, we32}, 64'h1);
        chk("lw_waddr", {59'h0, wa32}, 64'd9);
        chk("lw_wdata", {32'h0, wd32}, 64'hDEADBEEF);
        chk("lw_ready", {63'h0, b32.in_ready}, 64'h1);
        chk("lw_retired", ret32, 64'd9);
        tick();
        chk("held_add_wdata", {32'h0, wd32}, 64'h55);
        chk("held_add_waddr", {59'h0, wa32}, 64'd10);
        chk("held_add_retired", ret32, 64'd10);
        drv32(1'b0, ADD, 3'b000, 5'd0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0);
        tick();
        chk("single_pulse_we", {63'h0, we32}, 64'h0);

        // Reset while a load is pending, with competing valid/ack in the reset cycle.
        drv32(1'b1, LOAD, 3'b010, 5'd11, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0);
        tick();
        chk("pend_ready", {63'h0, b32.in_ready}, 64'h0);
        reset = 1'b1;
        drv32(1'b1, ADD, 3'b000, 5'd4, 32'h77, 32'h0, 3'b000, 32'hCAFEF00D, 1'b1);
        tick();
        reset = 1'b0;
        chk("rst_prio_we", {63'h0, we32}, 64'h0);
        chk("rst_prio_retired", ret32, 64'h0);
        drv32(1'b0, ADD, 3'b000, 5'd0, 32'h0, 32'h0, 3'b000, 32'hCAFEF00D, 1'b1);
        tick();
        b32.d_ack = 1'b0;
        tick();
        chk("rst_wait_we", {63'h0, we32}, 64'h0);
        chk("rst_wait_retired", ret32, 64'h0);
        chk("rst_wait_ready", {63'h0, b32.in_ready}, 64'h1);

        // 64-bit datapath: LWU zero extension and word/byte lane selection.
        drv64(1'b1, LOAD, 3'b110, 5'd12, 3'b000, 64'h12345678_FFFFFFFF, 1'b1);
        tick();
        chk("x64_lwu_wdata", wd64, 64'h00000000_FFFFFFFF);
        chk("x64_lwu_retired", ret64, 64'd1);
        drv64(1'b1, LOAD, 3'b010, 5'd13, 3'b100, 64'h80000000_00000000, 1'b1);
        tick();
        chk("x64_lw_hi_wdata", wd64, 64'hFFFFFFFF_80000000);
        drv64(1'b1, LOAD, 3'b000, 5'd14, 3'b111, 64'h80000000_00000000, 1'b1);
        tick();
        chk("x64_lb_b7_wdata", wd64, 64'hFFFFFFFF_FFFFFF80);
        chk("x64_lb_b7_waddr", {59'h0, wa64}, 64'd14);
        drv64(1'b0, ADD, 3'b000, 5'd0, 3'b000, 64'h0, 1'b0);
        tick();
        chk("x64_retired", ret64, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
